calc_arbiter: RTL and testbench
===============================

CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter: GAP_CYCLES, default 2, idle cycles enforced after each calculator strobe; legal range 0..15.
REQ-002 clock  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 (front panel) has a command pending.
REQ-005 req0_op  input  2  requester 0 opcode: 0 enter, 1 add, 2 multiply, 3 illegal.
REQ-006 req0_data  input  8  requester 0 operand.
REQ-007 req0_ready  output  1  requester 0 command accepted this cycle.
REQ-008 req1_valid, req1_op, req1_data, req1_ready: same as REQ-004..007, for requester 1 (script source).
REQ-009 enter, add, multiply  output  1 each  one-cycle strobes to the calculator; at most one high per cycle.
REQ-010 data  output  8  operand to the calculator.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 grant  output  1  index of the requester that issued the last accepted command.
REQ-013 err_illegal  output  1  one-cycle pulse on an accepted opcode 3.
REQ-014 issue_count0, issue_count1  output  8 each  strobes issued per requester.

Function
REQ-015 States: IDLE, SETUP, STROBE, GAP.
REQ-016 Transfer occurs when reqN_valid and reqN_ready are both high in the same cycle; reqN_ready is combinational and asserts only in IDLE, for at most one requester.
REQ-017 Arbitration is round-robin: one valid requester wins; two valid requesters → the one selected by the priority pointer wins, and the pointer then moves to the other requester.
REQ-018 Requesters hold valid, op and data stable until ready; deasserting valid before ready withdraws the request with no effect.
REQ-019 Accept in cycle T: data loads from the winner at the T edge (valid from T+1), grant updates, state → SETUP.
REQ-020 SETUP (T+1) → STROBE; STROBE (T+2) drives exactly one strobe matching the captured opcode.
REQ-021 After STROBE, GAP lasts GAP_CYCLES cycles, then → IDLE; GAP_CYCLES=0 goes STROBE → IDLE directly; minimum accept spacing = 3+GAP_CYCLES cycles.
REQ-022 Accepted opcode 3: err_illegal pulses in cycle T+1, no strobe, no count increment, state returns IDLE at T+2.
REQ-023 data holds its last value until the next accept; enter/add/multiply are low in every state except STROBE.
REQ-024 issue_countN increments by one in the STROBE cycle for the granted requester and wraps 255 → 0.

Reset
REQ-025 Reset forces state IDLE, data 0, grant 0, priority pointer to requester 0, all strobes, err_illegal, busy and ready low, and counters 0.
REQ-026 Reset asserted mid-sequence (SETUP, STROBE or GAP) suppresses any pending strobe; no strobe occurs in the reset cycle.

Configuration
REQ-027 Macro CALC_ARBITER_STATS_EN: when defined, issue_count0/1 behave per REQ-024; when undefined, both are tied to 0 and no counter registers are built.

Verification
REQ-028 req0 enter data=0x25, GAP_CYCLES=2 → req0_ready at T; data=0x25 from T+1; enter high only at T+2; busy T+1..T+4; next accept possible at T+5.
REQ-029 Both requesters valid continuously, each with op add → grants alternate 0,1,0,1; add pulses spaced exactly 5 cycles apart.
REQ-030 req1 op=3 data=0x7F → err_illegal high at T+1 only; no strobe; issue_count1 unchanged; IDLE at T+2.
REQ-031 Reset asserted in the SETUP cycle of a multiply → no multiply pulse; data=0 and busy=0 on the following cycle.
REQ-032 256 enter commands from req0 with CALC_ARBITER_STATS_EN defined → issue_count0 = 0 after wrap; without the macro → both counters always 0.
REQ-033 GAP_CYCLES=0, req0 holds valid with op enter → one enter every 3 cycles; a strobe is never asserted in two consecutive cycles.

Source files
------------

// File: rtl/calc_arbiter.sv
// calc_arbiter: round-robin arbiter feeding a calculator strobe interface.
// Optional macro CALC_ARBITER_STATS_EN builds the per-requester issue counters.
module calc_arbiter #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       enter,
    output logic       add,
    output logic       multiply,
    output logic [7:0] data,
    output logic       busy,
    output logic       grant,
    output logic       err_illegal,
    output logic [7:0] issue_count0,
    output logic [7:0] issue_count1
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP
    } state_t;

    state_t     state;
    logic [1:0] op_q;
    logic [3:0] gap_cnt;
    logic       prio;
    logic       enter_q;
    logic       add_q;
    logic       mul_q;
    logic       pick1;
    logic       accept;
    logic [1:0] win_op;
    logic [7:0] win_data;

    // winner selection: a lone requester wins, contention follows the pointer
    always_comb begin
        pick1    = req1_valid && (!req0_valid || prio);
        accept   = (state == IDLE) && !reset && (req0_valid || req1_valid);
        win_op   = pick1 ? req1_op : req0_op;
        win_data = pick1 ? req1_data : req0_data;
    end

    assign req0_ready = accept && !pick1;
    assign req1_ready = accept && pick1;
    assign busy       = (state != IDLE);

    // strobes are masked during reset so a pending pulse never escapes
    assign enter    = enter_q & ~reset;
    assign add      = add_q & ~reset;
    assign multiply = mul_q & ~reset;

    // command sequencer: accept, setup, strobe, then enforced idle gap
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            data        <= 8'd0;
            grant       <= 1'b0;
            prio        <= 1'b0;
            op_q        <= 2'd0;
            gap_cnt     <= 4'd0;
            enter_q     <= 1'b0;
            add_q       <= 1'b0;
            mul_q       <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            enter_q     <= 1'b0;
            add_q       <= 1'b0;
            mul_q       <= 1'b0;
            err_illegal <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        data        <= win_data;
                        grant       <= pick1;
                        op_q        <= win_op;
                        prio        <= ~pick1;
                        err_illegal <= (win_op == 2'd3);
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (op_q == 2'd3) begin
                        state <= IDLE;
                    end else begin
                        enter_q <= (op_q == 2'd0);
                        add_q   <= (op_q == 2'd1);
                        mul_q   <= (op_q == 2'd2);
                        state   <= STROBE;
                    end
                end
                STROBE: begin
                    if (GAP_CYCLES == 0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= 4'(GAP_CYCLES - 1);
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) state <= IDLE;
                    else gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CALC_ARBITER_STATS_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    // count each legal command as it enters its strobe cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else if (state == SETUP && op_q != 2'd3) begin
            if (grant) cnt1 <= cnt1 + 8'd1;
            else cnt0 <= cnt0 + 8'd1;
        end
    end

    assign issue_count0 = cnt0;
    assign issue_count1 = cnt1;
`else
    assign issue_count0 = 8'd0;
    assign issue_count1 = 8'd0;
`endif

endmodule

// File: tb/tb_calc_arbiter.sv
// tb_calc_arbiter: scoreboard bench for calc_arbiter.
// A second instance with GAP_CYCLES=0 covers back-to-back issue.
module tb_calc_arbiter;

`ifdef CALC_ARBITER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        logic       grant;
        int         cyc;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_op, req1_op;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       enter, add, multiply;
    logic [7:0] data;
    logic       busy, grant, err_illegal;
    logic [7:0] issue_count0, issue_count1;

    logic       g_req0_valid;
    logic [1:0] g_req0_op;
    logic [7:0] g_req0_data;
    logic       g_req0_ready, g_req1_ready;
    logic       g_enter, g_add, g_multiply;
    logic [7:0] g_data;
    logic       g_busy, g_grant, g_err;
    logic [7:0] g_cnt0, g_cnt1;

    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   exp_cnt0 = 0;
    int   exp_cnt1 = 0;
    exp_t exp_q[$];

    calc_arbiter #(.GAP_CYCLES(2)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_op(req0_op),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .enter(enter), .add(add), .multiply(multiply),
        .data(data), .busy(busy), .grant(grant),
        .err_illegal(err_illegal),
        .issue_count0(issue_count0), .issue_count1(issue_count1)
    );

    calc_arbiter #(.GAP_CYCLES(0)) dut_g0 (
        .clock(clock), .reset(reset),
        .req0_valid(g_req0_valid), .req0_op(g_req0_op),
        .req0_data(g_req0_data), .req0_ready(g_req0_ready),
        .req1_valid(1'b0), .req1_op(2'd0),
        .req1_data(8'd0), .req1_ready(g_req1_ready),
        .enter(g_enter), .add(g_add), .multiply(g_multiply),
        .data(g_data), .busy(g_busy), .grant(g_grant),
        .err_illegal(g_err),
        .issue_count0(g_cnt0), .issue_count1(g_cnt1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [2:0] k, input logic [7:0] d,
                        input logic g);
        exp_t e;
        e.kind  = k;
        e.data  = d;
        e.grant = g;
        e.cyc   = cyc + 2;
        exp_q.push_back(e);
        if (g) exp_cnt1 = (exp_cnt1 + 1) % 256;
        else exp_cnt0 = (exp_cnt0 + 1) % 256;
    endtask

    // monitor: every strobe must match the oldest expected command
    always @(negedge clock) begin
        if (enter || add || multiply) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {enter, add, multiply}, 3'b000);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_kind", {enter, add, multiply}, e.kind);
                chk("strobe_data", data, e.data);
                chk("strobe_grant", grant, e.grant);
                chk("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        req0_valid   = 1'b1;
        req0_op      = 2'd0;
        req0_data    = 8'h99;
        req1_valid   = 1'b0;
        req1_op      = 2'd0;
        req1_data    = 8'h00;
        g_req0_valid = 1'b0;
        g_req0_op    = 2'd0;
        g_req0_data  = 8'h00;
        repeat (2) tick();
        @(negedge clock);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", data, 8'h00);
        chk("rst_grant", grant, 1'b0);
        chk("rst_err", err_illegal, 1'b0);
        chk("rst_cnt0", issue_count0, 8'd0);
        chk("rst_cnt1", issue_count1, 8'd0);

        // single enter from req0
        tick();
        reset     = 1'b0;
        req0_data = 8'h25;
        push(3'b100, 8'h25, 1'b0);
        @(negedge clock);
        chk("a_ready0", req0_ready, 1'b1);
        chk("a_ready1", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        @(negedge clock);
        chk("a_data", data, 8'h25);
        chk("a_busy1", busy, 1'b1);
        chk("a_grant", grant, 1'b0);
        chk("a_err", err_illegal, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            @(negedge clock);
            chk("a_busy", busy, 1'b1);
        end
        tick();
        req1_valid = 1'b1;
        req1_op    = 2'd1;
        req1_data  = 8'h11;
        push(3'b010, 8'h11, 1'b1);
        @(negedge clock);
        chk("a_idle", busy, 1'b0);
        chk("a_ready1_t5", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        @(negedge clock);
        chk("a_grant1", grant, 1'b1);
        repeat (4) tick();

        // contention: both requesters hold add commands
        req0_valid = 1'b1;
        req0_op    = 2'd1;
        req0_data  = 8'h0A;
        req1_valid = 1'b1;
        req1_op    = 2'd1;
        req1_data  = 8'h0B;
        for (int k = 0; k < 4; k++) begin
            logic w;
            w = (k % 2) != 0;
            push(3'b010, w ? 8'h0B : 8'h0A, w);
            @(negedge clock);
            chk("b_ready0", req0_ready, !w);
            chk("b_ready1", req1_ready, w);
            repeat (5) tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clock);
        chk("b_cnt0", issue_count0, STATS ? exp_cnt0 : 0);
        chk("b_cnt1", issue_count1, STATS ? exp_cnt1 : 0);

        // illegal opcode from req1
        tick();
        req1_valid = 1'b1;
        req1_op    = 2'd3;
        req1_data  = 8'h7F;
        @(negedge clock);
        chk("c_ready1", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        @(negedge clock);
        chk("c_err_t1", err_illegal, 1'b1);
        chk("c_data", data, 8'h7F);
        chk("c_busy_t1", busy, 1'b1);
        tick();
        @(negedge clock);
        chk("c_err_t2", err_illegal, 1'b0);
        chk("c_idle_t2", busy, 1'b0);
        chk("c_cnt1", issue_count1, STATS ? exp_cnt1 : 0);

        // reset during SETUP of a multiply
        tick();
        req0_valid = 1'b1;
        req0_op    = 2'd2;
        req0_data  = 8'h33;
        @(negedge clock);
        chk("d_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clock);
        chk("d_busy_setup", busy, 1'b1);
        tick();
        reset    = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        @(negedge clock);
        chk("d_data", data, 8'h00);
        chk("d_busy", busy, 1'b0);
        chk("d_mul", multiply, 1'b0);

        // reset during the STROBE cycle of an enter
        tick();
        req0_valid = 1'b1;
        req0_op    = 2'd0;
        req0_data  = 8'h44;
        @(negedge clock);
        chk("w_ready0", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("w_enter_in_reset", enter, 1'b0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("w_busy", busy, 1'b0);
        chk("w_cnt0", issue_count0, 8'd0);

        // 256 back-to-back enters from req0 to wrap the counter
        tick();
        req0_valid = 1'b1;
        req0_op    = 2'd0;
        for (int i = 0; i < 256; i++) begin
            req0_data = 8'(i);
            push(3'b100, 8'(i), 1'b0);
            if (i == 100) begin
                @(negedge clock);
                chk("e_cnt0_mid", issue_count0, STATS ? 8'd100 : 8'd0);
            end
            repeat (5) tick();
        end
        req0_valid = 1'b0;
        repeat (2) tick();
        @(negedge clock);
        chk("e_cnt0_wrap", issue_count0, STATS ? exp_cnt0 : 0);
        chk("e_cnt1", issue_count1, 8'd0);

        // zero-gap instance: one enter every 3 cycles
        tick();
        g_req0_valid = 1'b1;
        g_req0_op    = 2'd0;
        g_req0_data  = 8'h5A;
        for (int j = 0; j < 30; j++) begin
            @(negedge clock);
            chk("g_enter", g_enter, (j % 3) == 2);
            chk("g_ready0", g_req0_ready, (j % 3) == 0);
            tick();
        end
        g_req0_valid = 1'b0;
        repeat (4) tick();
        @(negedge clock);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
